pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage MIPS core. It replaces per-stage ad-hoc stall logic with one FSM that arbitrates between data-memory wait stalls, load-use interlocks and taken-branch flushes. It drives the write enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also provides a memory-timeout error and saturating stall/flush performance counters.

---
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central sequencing controller for the 5-stage pipeline: arbitrates data-memory
// waits, load-use interlocks and taken-branch flushes, with timeout error and perf counters.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                mem_err_reg, mem_err_next;
    logic [CNT_W-1:0]    stall_cnt_reg, flush_cnt_reg;

    logic mem_stall;
    logic load_use;

    assign mem_stall = (state_reg != ERR) && mem_req_i && !mem_ack_i;
    assign load_use  = ex_memread_i && (ex_rt_i != 5'd0) &&
                       ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_write_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        mem_err_next   = mem_err_reg;

        if (!rst_i && state_reg != ERR) begin
            if (mem_stall) begin
                memwb_bubble_o = 1'b1;
                if (state_reg == RUN) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_next   = ERR;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end else begin
                // Ack (or a dropped request) ends any wait; the pipeline advances now.
                state_next    = RUN;
                wait_cnt_next = '0;
                idex_write_o  = 1'b1;
                exmem_write_o = 1'b1;
                if (load_use) begin
                    idex_bubble_o = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = branch_taken_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    // Saturating counters; frozen ERR cycles are not counted as stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (state_reg != ERR && !pc_write_o && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (ifid_flush_o && flush_cnt_reg != {CNT_W{1'b1}})
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign state_o     = state_reg;
    assign mem_err_o   = mem_err_reg;
    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MEM_TIMEOUT=4, CNT_W=2 so timeout and saturation are reachable).
module tb_pipe_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             ex_memread, branch_taken, mem_req, mem_ack;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic             exmem_write, memwb_bubble, mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_rt_i(ex_rt),
        .ex_memread_i(ex_memread), .branch_taken_i(branch_taken),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_write_o(idex_write), .idex_bubble_o(idex_bubble),
        .exmem_write_o(exmem_write), .memwb_bubble_o(memwb_bubble),
        .mem_err_o(mem_err), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    // Dropping mem_req while waiting without an ack is a protocol violation.
    always @(negedge clk) begin
        if (!rst && state == 2'd1 && !mem_req)
            $error("protocol: mem_req dropped in MEM_WAIT without ack");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Packed control outputs {pc,ifid_w,flush,idex_w,idex_b,exmem_w,memwb_b}.
    function automatic logic [6:0] ctl();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble};
    endfunction

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        ex_memread = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; idle();
        #2;
        rst = 1'b0;
        step();
    endtask

    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_BRANCH = 7'b1111010;
    localparam logic [6:0] C_LOADU  = 7'b0001110;
    localparam logic [6:0] C_MEMST  = 7'b0000001;
    localparam logic [6:0] C_FROZEN = 7'b0000000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; idle();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
        #3;
        check("rst_ctl_forced0", ctl(), C_FROZEN);
        check("rst_state", state, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_mem_err", mem_err, 0);
        idle();
        @(negedge clk); rst = 1'b0;
        step();

        // 1. load-use via rs, then ex_rt=0, then via rt
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        sample(); check("lu_rs_ctl", ctl(), C_LOADU);
        step(); idle();
        sample(); check("lu_stall_cnt", stall_cnt, 1);
        check("lu_after_ctl", ctl(), C_NORMAL);
        step();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        sample(); check("lu_r0_ctl", ctl(), C_NORMAL);
        step();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd4; id_rt = 5'd9;
        sample(); check("lu_r0_stall_cnt", stall_cnt, 1);
        check("lu_rt_ctl", ctl(), C_LOADU);
        step(); idle();
        sample(); check("lu_rt_stall_cnt", stall_cnt, 2);

        // 2. branch alone, then branch + load-use
        step();
        branch_taken = 1'b1;
        sample(); check("br_ctl", ctl(), C_BRANCH);
        step();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        sample(); check("br_flush_cnt", flush_cnt, 1);
        check("br_lu_ctl", ctl(), C_LOADU);
        step(); idle();
        sample(); check("br_lu_flush_cnt", flush_cnt, 1);
        check("br_lu_stall_cnt", stall_cnt, 3);

        // 3. memory miss acked after 3 stalled cycles
        do_reset();
        mem_req = 1'b1;
        sample(); check("mm_c1_state", state, 0); check("mm_c1_ctl", ctl(), C_MEMST);
        step();
        sample(); check("mm_c2_state", state, 1); check("mm_c2_ctl", ctl(), C_MEMST);
        step();
        sample(); check("mm_c3_state", state, 1); check("mm_c3_ctl", ctl(), C_MEMST);
        step(); mem_ack = 1'b1;
        sample(); check("mm_ack_state", state, 1); check("mm_ack_ctl", ctl(), C_NORMAL);
        step(); idle();
        sample(); check("mm_end_state", state, 0); check("mm_stall_cnt", stall_cnt, 3);

        // 4a. timeout with no ack
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); check($sformatf("to_c%0d_ctl", i + 1), ctl(), C_MEMST);
            step();
        end
        sample();
        check("to_state", state, 2);
        check("to_mem_err", mem_err, 1);
        check("to_ctl", ctl(), C_FROZEN);
        check("to_stall_cnt", stall_cnt, 3);
        step(); idle(); branch_taken = 1'b1; mem_ack = 1'b1;
        sample();
        check("err_frozen_ctl", ctl(), C_FROZEN);
        check("err_hold_state", state, 2);
        step();
        sample(); check("err_flush_cnt", flush_cnt, 0);
        check("err_hold_mem_err", mem_err, 1);

        // 4b. ack on the 4th stalled cycle wins over the timeout
        do_reset();
        mem_req = 1'b1;
        step(); step(); step();
        mem_ack = 1'b1;
        sample(); check("to_ack_ctl", ctl(), C_NORMAL);
        step(); idle();
        sample(); check("to_ack_state", state, 0); check("to_ack_mem_err", mem_err, 0);

        // 5. priority: mem stall over load-use and branch
        do_reset();
        mem_req = 1'b1; ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; branch_taken = 1'b1;
        sample(); check("pri_ctl", ctl(), C_MEMST);
        step(); idle(); mem_req = 1'b1; mem_ack = 1'b1;
        sample(); check("pri_ack_ctl", ctl(), C_NORMAL);
        step(); idle();
        sample(); check("pri_flush_cnt", flush_cnt, 0); check("pri_stall_cnt", stall_cnt, 1);

        // 6a. asynchronous reset while in MEM_WAIT
        step();
        mem_req = 1'b1;
        step(); step();
        #2;
        check("ar_pre_state", state, 1);
        rst = 1'b1;
        #1;
        check("ar_state", state, 0);
        check("ar_stall_cnt", stall_cnt, 0);
        check("ar_ctl", ctl(), C_FROZEN);
        idle();
        @(negedge clk); rst = 1'b0;
        step();

        // 6b. saturation of both counters at 3
        ex_memread = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
        for (int i = 0; i < 5; i++) step();
        idle(); branch_taken = 1'b1;
        sample(); check("sat_stall_cnt", stall_cnt, 3);
        for (int i = 0; i < 5; i++) step();
        idle();
        sample(); check("sat_flush_cnt", flush_cnt, 3);
        check("sat_stall_hold", stall_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
